// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the IF/ID/EX front end: resolves load-use and
// load-fed branch hazards with bubbles, flushes on taken branch, latches halt.
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       HazardDetected,
  input  logic [3:0]       IDOP1,
  input  logic [3:0]       IDOP2,
  input  logic             IDUsesOP2,
  input  logic             IDIsBranch,
  input  logic             IDIsHalt,
  input  logic             BranchTaken,
  input  logic [3:0]       OpcodeEX,
  input  logic [3:0]       EXDest,
  input  logic             EXWritesReg,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [1:0]       stall_left_r;
  logic [1:0]       next_stall_left_s;
  logic             halted_r;
  logic [CNT_W-1:0] stall_count_r;
  logic             stall_s;
  logic             ex_is_load_s;
  logic             load_use_s;
  logic             br_haz_s;
  logic             unused_s;

  // EX-operand hazard flag is informational; forwarding already covers it.
  assign unused_s = HazardDetected[0];

  // Hazard classification from the ID and EX register IDs.
  always_comb begin
    ex_is_load_s = (OpcodeEX == 4'b0100) || (OpcodeEX == 4'b0110);
    load_use_s   = ex_is_load_s && EXWritesReg &&
                   ((EXDest == IDOP1) || (IDUsesOP2 && (EXDest == IDOP2)));
    br_haz_s     = IDIsBranch && HazardDetected[1];
  end

  // Next-state and enable generation; enables react in the hazard cycle itself.
  always_comb begin
    next_state_s      = state_r;
    next_stall_left_s = stall_left_r;
    stall_s           = 1'b0;
    PCWrite           = 1'b1;
    IFIDWrite         = 1'b1;
    IDEXBubble        = 1'b0;
    IFIDFlush         = 1'b0;
    if (reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      IFIDFlush  = 1'b1;
      next_state_s      = ST_RUN;
      next_stall_left_s = 2'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (IDIsHalt) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXBubble   = 1'b1;
            next_state_s = ST_HALT;
          end else if (br_haz_s && ex_is_load_s) begin
            // Branch needs the loaded value in ID: two bubbles before it resolves.
            PCWrite           = 1'b0;
            IFIDWrite         = 1'b0;
            IDEXBubble        = 1'b1;
            stall_s           = 1'b1;
            next_stall_left_s = 2'd1;
            next_state_s      = ST_STALL;
          end else if (load_use_s || br_haz_s) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            stall_s    = 1'b1;
          end else if (BranchTaken) begin
            IFIDFlush = 1'b1;
          end else begin
            IFIDFlush = 1'b0;
          end
        end
        ST_STALL: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
          stall_s    = 1'b1;
          // The final decrement to zero also ends the stall.
          if (stall_left_r <= 2'd1) begin
            next_stall_left_s = 2'd0;
            next_state_s      = ST_RUN;
          end else begin
            next_stall_left_s = stall_left_r - 2'd1;
          end
        end
        ST_HALT: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
        default: begin
          PCWrite      = 1'b0;
          IFIDWrite    = 1'b0;
          IDEXBubble   = 1'b1;
          next_state_s      = ST_RUN;
          next_stall_left_s = 2'd0;
        end
      endcase
    end
  end

  // State, halt flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RUN;
      stall_left_r  <= 2'd0;
      halted_r      <= 1'b0;
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= next_state_s;
      stall_left_r <= next_stall_left_s;
      halted_r     <= (next_state_s == ST_HALT);
      if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
        stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign Halted     = halted_r;
  assign StallCount = stall_count_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized bench for hazard_control_unit against a bubble-budget reference
// model; a second instance with a 2-bit counter exercises saturation.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] hd = 2'd0;
  logic [3:0] op1 = 4'd0, op2 = 4'd0, opex = 4'd0, exdest = 4'd0;
  logic       uses2 = 1'b0, br = 1'b0, halt = 1'b0, taken = 1'b0, exwr = 1'b0;

  logic        a_pcw, a_ifw, a_bub, a_fl, a_halted;
  logic [15:0] a_cnt;
  logic        b_pcw, b_ifw, b_bub, b_fl, b_halted;
  logic [1:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: outstanding extra bubbles, halt latch, stall tallies.
  int          m_pending = 0;
  bit          m_halted = 1'b0;
  int unsigned m_cnt16 = 0;
  int unsigned m_cnt2 = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .HazardDetected(hd), .IDOP1(op1), .IDOP2(op2),
    .IDUsesOP2(uses2), .IDIsBranch(br), .IDIsHalt(halt), .BranchTaken(taken),
    .OpcodeEX(opex), .EXDest(exdest), .EXWritesReg(exwr),
    .PCWrite(a_pcw), .IFIDWrite(a_ifw), .IDEXBubble(a_bub), .IFIDFlush(a_fl),
    .Halted(a_halted), .StallCount(a_cnt)
  );

  hazard_control_unit #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .HazardDetected(hd), .IDOP1(op1), .IDOP2(op2),
    .IDUsesOP2(uses2), .IDIsBranch(br), .IDIsHalt(halt), .BranchTaken(taken),
    .OpcodeEX(opex), .EXDest(exdest), .EXWritesReg(exwr),
    .PCWrite(b_pcw), .IFIDWrite(b_ifw), .IDEXBubble(b_bub), .IFIDFlush(b_fl),
    .Halted(b_halted), .StallCount(b_cnt)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic rst, input logic [1:0] h, input logic [3:0] o1,
                        input logic [3:0] o2, input logic u2, input logic b,
                        input logic hl, input logic tk, input logic [3:0] oe,
                        input logic [3:0] ed, input logic ew);
    reset = rst; hd = h; op1 = o1; op2 = o2; uses2 = u2; br = b;
    halt = hl; taken = tk; opex = oe; exdest = ed; exwr = ew;
  endtask

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic step();
    bit is_load, lu, bh, stall, to_halt;
    logic [3:0] exp_en;
    int new_pending;
    @(negedge clk);
    is_load = (opex == 4'd4) || (opex == 4'd6);
    lu = is_load && exwr && ((exdest == op1) || (uses2 && (exdest == op2)));
    bh = br && hd[1];
    stall = 1'b0;
    to_halt = 1'b0;
    new_pending = m_pending;
    if (reset)                 exp_en = 4'b0011;
    else if (m_halted)         exp_en = 4'b0010;
    else if (m_pending > 0) begin
      exp_en = 4'b0010; stall = 1'b1; new_pending = m_pending - 1;
    end
    else if (halt)         begin exp_en = 4'b0010; to_halt = 1'b1; end
    else if (bh && is_load) begin exp_en = 4'b0010; stall = 1'b1; new_pending = 1; end
    else if (lu || bh)     begin exp_en = 4'b0010; stall = 1'b1; end
    else if (taken)            exp_en = 4'b1101;
    else                       exp_en = 4'b1100;
    // exp_en = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}
    check_value("enables_a", {28'd0, a_pcw, a_ifw, a_bub, a_fl}, {28'd0, exp_en});
    check_value("enables_b", {28'd0, b_pcw, b_ifw, b_bub, b_fl}, {28'd0, exp_en});
    check_value("halted", {30'd0, a_halted, b_halted}, {30'd0, m_halted, m_halted});
    check_value("count16", {16'd0, a_cnt}, m_cnt16);
    check_value("count2", {30'd0, b_cnt}, m_cnt2);
    if (reset) begin
      m_pending = 0; m_halted = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
    end else begin
      m_pending = new_pending;
      m_halted = m_halted | to_halt;
      if (stall) begin
        if (m_cnt16 < 32'd65535) m_cnt16++;
        if (m_cnt2 < 32'd3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    set_in(1'b1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step();
    // Load-use on OP1: one bubble, then free running
    set_in(1'b0, 2'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 4'd3, 1'b1);
    step();
    set_in(1'b0, 2'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1);
    step();
    check_value("loaduse_count", {16'd0, a_cnt}, 32'd1);
    // OP2 qualification
    set_in(1'b0, 2'd0, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 4'd3, 1'b1);
    step();
    set_in(1'b0, 2'd0, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'd3, 1'b1);
    step();
    // Branch behind a load: inputs clear during the second bubble
    set_in(1'b1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step();
    set_in(1'b0, 2'b10, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 4'd9, 1'b1);
    step();
    set_in(1'b0, 2'b00, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd9, 1'b0);
    step();
    step();
    check_value("brload_count", {16'd0, a_cnt}, 32'd2);
    // Taken branch alone, then taken branch under load-use
    set_in(1'b0, 2'd0, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    step();
    set_in(1'b0, 2'd0, 4'd7, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 4'd7, 1'b1);
    step();
    // Saturation: five more stalls push the 2-bit counter to its ceiling
    for (int i = 0; i < 5; i++) step();
    check_value("sat_count", {30'd0, b_cnt}, 32'd3);
    // Reset in the middle of a two-bubble stall
    set_in(1'b0, 2'b10, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'd0, 1'b0);
    step();
    set_in(1'b1, 2'b10, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'd0, 1'b0);
    step();
    set_in(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step();
    check_value("midstall_rst", {28'd0, a_pcw, 1'b0, b_cnt}, {28'd0, 1'b1, 1'b0, 2'd0});
    // Halt together with load-use: halt wins, sticks for 20 cycles
    set_in(1'b0, 2'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 4'd3, 1'b1);
    step();
    set_in(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check_value("halt_count", {16'd0, a_cnt}, 32'd0);
    set_in(1'b1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step();
    set_in(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step();
    // Randomized traffic with narrow register IDs to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
             4'($urandom_range(3, 7)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Stall/flush controller that acts on the forwarding unit's `HazardDetected` flags and the pipeline register IDs. Sits between the ID/EX hazard logic and the PC, IF/ID and ID/EX pipeline registers. It is the responder to the register forwarding unit: it takes over where forwarding alone cannot resolve a dependency. It generates PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush on taken branch, and a permanent halt. It also keeps a stall-cycle performance counter.

## Interface
Parameters
- `CNT_W`, 16, width of the stall performance counter.

Ports
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `HazardDetected`  in  2  from the forwarding unit. Bit 1 is a branch-operand hazard; bit 0 is an EX-operand hazard (informational only).
- `IDOP1`, `IDOP2`  in  4 each  source register IDs of the instruction in ID.
- `IDUsesOP2`  in  1  ID instruction reads `IDOP2`.
- `IDIsBranch`  in  1  ID instruction is a conditional branch.
- `IDIsHalt`  in  1  ID instruction is halt.
- `BranchTaken`  in  1  branch in ID resolved taken this cycle.
- `OpcodeEX`  in  4  opcode in EX.
- `EXDest`  in  4  destination register ID in EX.
- `EXWritesReg`  in  1  EX instruction writes `EXDest`.
- `PCWrite`  out  1  PC load enable.
- `IFIDWrite`  out  1  IF/ID register load enable.
- `IDEXBubble`  out  1  load NOP into ID/EX this cycle.
- `IFIDFlush`  out  1  clear IF/ID this cycle.
- `Halted`  out  1  core halted.
- `StallCount`  out  CNT_W  saturating count of hazard stall cycles.

## Operation
- States: RUN, STALL, HALT. The state is 2-bit registered. `stall_left` is a 2-bit registered counter.
- EX is a load when `OpcodeEX` == 4'b0100 or 4'b0110.
- load_use = EX is a load & `EXWritesReg` & (`EXDest`==`IDOP1` | (`IDUsesOP2` & `EXDest`==`IDOP2`)).
- br_haz = `IDIsBranch` & `HazardDetected[1]`.
- RUN evaluates the following in priority order (first match wins):
  1. `IDIsHalt`: outputs PCWrite=0, IFIDWrite=0, IDEXBubble=1. Next state is HALT.
  2. br_haz & EX is a load: stall. Load stall_left=1. Next state is STALL (2 stall cycles total).
  3. load_use or br_haz: stall for 1 cycle. Next state stays RUN, and re-evaluates next cycle.
  4. `BranchTaken`: IFIDFlush=1, PCWrite=1, IFIDWrite=1.
  5. Otherwise: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.
- "Stall" means PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
- `BranchTaken` is ignored in any cycle where a stall or halt is asserted. The branch re-resolves after the stall.
- STALL: outputs stall. All hazard inputs are ignored. `stall_left` decrements each cycle. When `stall_left`==0, the unit returns to RUN at the next edge.
- HALT: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, `Halted`=1. The unit leaves HALT only on reset.
- `StallCount` increments by 1 on each cycle that outputs a stall in RUN or STALL. It saturates at all ones. Halt cycles are not counted.
- Outputs are combinational from the registered state and the current inputs. There are no registered outputs except `Halted` and `StallCount`.

## Timing
- Reset (sampled high at an edge) sets: state=RUN, stall_left=0, Halted=0, StallCount=0.
- While `reset` is high, outputs are forced to PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=1, regardless of state.
- Reset asserted mid-STALL or in HALT aborts the stall or halt at that edge.
- Stall decision latency is 0 cycles: enables drop in the same cycle the hazard is present in ID/EX.
- Load-use gives exactly 1 bubble: the load moves to MEM, and the forwarding unit supplies the data from then on.
- A load-feeding branch gives exactly 2 bubbles. The branch evaluates in the third cycle.
- `Halted` rises on the edge that ends the halt-detect cycle.
- `StallCount` updates on the edge ending each stall cycle. It is visible the next cycle.
- Simultaneous `IDIsHalt` and load_use: halt wins. No stall is counted.

## Test plan
- Load-use stall: reset, then OpcodeEX=4'b0110, EXDest=3, EXWritesReg=1, IDOP1=3. Required: one cycle with PCWrite=0 and IDEXBubble=1. Next cycle (OpcodeEX=0) PCWrite=1. StallCount=1.
- OP2 qualification: same as the load-use case but IDOP1=5, IDOP2=3, with IDUsesOP2 toggled. With IDUsesOP2=0: no stall. With IDUsesOP2=1: 1-cycle stall.
- Branch behind a load: IDIsBranch=1, HazardDetected=2'b10, OpcodeEX=4'b0100. Required: 2 consecutive stall cycles even if the inputs change during the second cycle. Return to RUN. StallCount=2.
- Taken branch vs stall: assert BranchTaken=1 with no hazard. Required: IFIDFlush=1 for 1 cycle. Then assert BranchTaken=1 together with load_use. Required: IFIDFlush=0 and stall.
- Halt: IDIsHalt=1 for 1 cycle, then clear it. Required: Halted=1 from the next cycle and PCWrite stays 0 for 20 cycles. Reset high for 1 cycle returns the unit to RUN and clears Halted.
- Saturation/reset: build with CNT_W=2 and force 5 stall cycles. Required: StallCount=3. Reset asserted mid-STALL clears StallCount to 0 and the next cycle is RUN.
